// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and constants for the FP adder normalizer stage
//
// Purpose: state encoding, result classification and default format constants
// used by addition_stage4 and its shift helper.
// Ports: none (package).
package fpu_pkg;

  localparam int FP_MENT_WIDTH = 23;
  localparam int FP_EXP_WIDTH  = 8;

  // Bit positions inside the (MENT_WIDTH+2)-bit stage-3 sum.
  localparam int CARRY_BIT  = FP_MENT_WIDTH + 1;
  localparam int HIDDEN_BIT = FP_MENT_WIDTH;

  // All-ones biased exponent (infinity / overflow marker).
  localparam logic [FP_EXP_WIDTH-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_SHIFT,
    ST_DONE
  } norm_state_t;

  // How the finished result is presented on the output registers.
  typedef enum logic [1:0] {
    RES_NORMAL,
    RES_ZERO,
    RES_OVERFLOW,
    RES_UNDERFLOW
  } norm_result_t;

endpackage

// File: rtl/normalize_shift_unit.sv
// rtl/normalize_shift_unit.sv - one-step mantissa shift and exponent update
//
// Purpose: combinational candidates for a single normalization step.
// Ports:
//   sum_in  - working mantissa (carry, hidden, fraction)
//   exp_in  - working exponent, one guard bit wider than the format
//   sum_rsh - sum shifted right by one (LSB truncated)
//   exp_inc - exp_in + 1
//   sum_lsh - sum shifted left by one
//   exp_dec - exp_in - 1
module normalize_shift_unit #(
  parameter int MENT_WIDTH = 23,
  parameter int EXP_WIDTH  = 8
) (
  input  logic [MENT_WIDTH+1:0] sum_in,
  input  logic [EXP_WIDTH:0]    exp_in,
  output logic [MENT_WIDTH+1:0] sum_rsh,
  output logic [EXP_WIDTH:0]    exp_inc,
  output logic [MENT_WIDTH+1:0] sum_lsh,
  output logic [EXP_WIDTH:0]    exp_dec
);

  localparam logic [EXP_WIDTH:0] EXP_ONE = {{EXP_WIDTH{1'b0}}, 1'b1};

  assign sum_rsh = sum_in >> 1;
  assign sum_lsh = sum_in << 1;
  // The extra exponent bit lets an increment past all-ones be seen instead of wrapping.
  assign exp_inc = exp_in + EXP_ONE;
  assign exp_dec = exp_in - EXP_ONE;

endmodule

// File: rtl/addition_stage4.sv
// rtl/addition_stage4.sv - FP adder stage 4: mantissa/exponent normalizer
//
// Purpose: renormalizes the stage-3 mantissa sum to hidden-1 form (one right
// shift on carry-out, iterative left shifts on cancellation) and returns sign,
// exponent, fraction and zero/overflow/underflow flags via valid/ready.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   in_valid / in_ready       - input handshake (ready only while idle)
//   sum_in, exp_in, sign_in   - stage-3 sum, common exponent, result sign
//   out_valid / out_ready     - output handshake (valid held until accepted)
//   sign_out, exp_out, ment_out - normalized result, hidden bit stripped
//   zero_out, overflow_out, underflow_out - registered result flags
module addition_stage4
  import fpu_pkg::*;
#(
  parameter int MENT_WIDTH = FP_MENT_WIDTH,
  parameter int EXP_WIDTH  = FP_EXP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MENT_WIDTH+1:0] sum_in,
  input  logic [EXP_WIDTH-1:0]  exp_in,
  input  logic                  sign_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sign_out,
  output logic [EXP_WIDTH-1:0]  exp_out,
  output logic [MENT_WIDTH-1:0] ment_out,
  output logic                  zero_out,
  output logic                  overflow_out,
  output logic                  underflow_out
);

  localparam int CARRY  = MENT_WIDTH + 1;
  localparam int HIDDEN = MENT_WIDTH;
  localparam logic [EXP_WIDTH:0] EXP_ONES = {1'b0, {EXP_WIDTH{1'b1}}};
  localparam logic [EXP_WIDTH:0] EXP_ONE  = {{EXP_WIDTH{1'b0}}, 1'b1};

  norm_state_t state_q, state_d;

  // Working registers
  logic [MENT_WIDTH+1:0] sum_q, sum_d;
  logic [EXP_WIDTH:0]    exp_q, exp_d;
  logic                  sign_q, sign_d;

  // Output registers
  logic                  res_sign_q, res_sign_d;
  logic [EXP_WIDTH-1:0]  res_exp_q, res_exp_d;
  logic [MENT_WIDTH-1:0] res_ment_q, res_ment_d;
  logic                  zero_q, zero_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  // One-step candidates
  logic [MENT_WIDTH+1:0] sum_rsh, sum_lsh;
  logic [EXP_WIDTH:0]    exp_inc, exp_dec;

  // Finish decision for this cycle
  logic                  fin;
  norm_result_t          kind;
  logic [EXP_WIDTH-1:0]  norm_exp;
  logic [MENT_WIDTH-1:0] norm_ment;

  normalize_shift_unit #(
    .MENT_WIDTH (MENT_WIDTH),
    .EXP_WIDTH  (EXP_WIDTH)
  ) u_shift (
    .sum_in  (sum_q),
    .exp_in  (exp_q),
    .sum_rsh (sum_rsh),
    .exp_inc (exp_inc),
    .sum_lsh (sum_lsh),
    .exp_dec (exp_dec)
  );

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    res_sign_d = res_sign_q;
    res_exp_d  = res_exp_q;
    res_ment_d = res_ment_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    fin        = 1'b0;
    kind       = RES_NORMAL;
    norm_exp   = exp_q[EXP_WIDTH-1:0];
    norm_ment  = sum_q[MENT_WIDTH-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sum_d   = sum_in;
          exp_d   = {1'b0, exp_in};
          sign_d  = sign_in;
          state_d = ST_EVAL;
        end
      end

      ST_EVAL: begin
        fin = 1'b1;
        if (exp_q == EXP_ONES) begin
          kind = RES_OVERFLOW;
        end else if (sum_q == '0) begin
          kind = RES_ZERO;
        end else if (sum_q[CARRY]) begin
          sum_d     = sum_rsh;
          exp_d     = exp_inc;
          norm_exp  = exp_inc[EXP_WIDTH-1:0];
          norm_ment = sum_rsh[MENT_WIDTH-1:0];
          kind      = (exp_inc == EXP_ONES) ? RES_OVERFLOW : RES_NORMAL;
        end else if (sum_q[HIDDEN]) begin
          kind = RES_NORMAL;
        end else if (exp_q <= EXP_ONE) begin
          kind = RES_UNDERFLOW;
        end else begin
          fin     = 1'b0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sum_d = sum_lsh;
        exp_d = exp_dec;
        // Hidden bit wins over the exponent floor: reaching exp 1 normalized is a valid number.
        if (sum_lsh[HIDDEN]) begin
          fin       = 1'b1;
          kind      = RES_NORMAL;
          norm_exp  = exp_dec[EXP_WIDTH-1:0];
          norm_ment = sum_lsh[MENT_WIDTH-1:0];
        end else if (exp_dec == EXP_ONE) begin
          fin  = 1'b1;
          kind = RES_UNDERFLOW;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      state_d    = ST_DONE;
      res_sign_d = sign_q;
      res_exp_d  = '0;
      res_ment_d = '0;
      zero_d     = 1'b0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      case (kind)
        RES_NORMAL: begin
          res_exp_d  = norm_exp;
          res_ment_d = norm_ment;
        end
        RES_ZERO: zero_d = 1'b1;
        RES_OVERFLOW: begin
          res_exp_d = '1;
          ovf_d     = 1'b1;
        end
        RES_UNDERFLOW: begin
          // Flush to zero: denormals are never produced.
          zero_d = 1'b1;
          unf_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sum_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      res_sign_q <= 1'b0;
      res_exp_q  <= '0;
      res_ment_q <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      res_sign_q <= res_sign_d;
      res_exp_q  <= res_exp_d;
      res_ment_q <= res_ment_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = (state_q == ST_DONE);
  assign sign_out      = res_sign_q;
  assign exp_out       = res_exp_q;
  assign ment_out      = res_ment_q;
  assign zero_out      = zero_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;

endmodule

// File: tb/tb_addition_stage4.sv
// tb/tb_addition_stage4.sv - self-checking bench for addition_stage4
module tb_addition_stage4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] sum_in;
  logic [7:0]  exp_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [22:0] ment_out;
  logic        zero_out;
  logic        overflow_out;
  logic        underflow_out;

  addition_stage4 dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sum_in        (sum_in),
    .exp_in        (exp_in),
    .sign_in       (sign_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sign_out      (sign_out),
    .exp_out       (exp_out),
    .ment_out      (ment_out),
    .zero_out      (zero_out),
    .overflow_out  (overflow_out),
    .underflow_out (underflow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] ment;
    logic        z;
    logic        o;
    logic        u;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   first = 1'b1;
  bit   hs_prev = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: value-level normalization. Left shifts needed = 23 - msb index;
  // the exponent may not go below 1, otherwise the result flushes to zero after
  // the shifts that were possible.
  function automatic exp_t model(input logic [24:0] s, input logic [7:0] e, input logic sg);
    exp_t r;
    int ei;
    int p;
    int n;
    logic [24:0] t;
    ei = int'(e);
    r.sign = sg; r.exp = 8'd0; r.ment = 23'd0;
    r.z = 1'b0; r.o = 1'b0; r.u = 1'b0; r.lat = 2; r.acc = 0;
    if (ei == 255) begin
      r.exp = 8'hFF; r.o = 1'b1;
    end else if (s == 25'd0) begin
      r.z = 1'b1;
    end else if (s >= 25'h1000000) begin
      if (ei + 1 == 255) begin
        r.exp = 8'hFF; r.o = 1'b1;
      end else begin
        t = s >> 1;
        r.exp = 8'(ei + 1); r.ment = t[22:0];
      end
    end else if (s >= 25'h0800000) begin
      r.exp = e; r.ment = s[22:0];
    end else if (ei <= 1) begin
      r.z = 1'b1; r.u = 1'b1;
    end else begin
      p = 0;
      for (int i = 0; i < 23; i++) if (s[i]) p = i;
      n = 23 - p;
      if (ei - n >= 1) begin
        t = s << n;
        r.exp = 8'(ei - n); r.ment = t[22:0]; r.lat = 2 + n;
      end else begin
        r.z = 1'b1; r.u = 1'b1; r.lat = 2 + (ei - 1);
      end
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every cycle out_valid is high, check against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      first = 1'b1;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
      hs_prev = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1, required 0 (no pending input)");
        end else begin
          e = q[0];
          if (first) begin
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            first = 1'b0;
          end
          chk("sign_out",      {31'd0, sign_out},      {31'd0, e.sign});
          chk("exp_out",       {24'd0, exp_out},       {24'd0, e.exp});
          chk("ment_out",      {9'd0, ment_out},       {9'd0, e.ment});
          chk("zero_out",      {31'd0, zero_out},      {31'd0, e.z});
          chk("overflow_out",  {31'd0, overflow_out},  {31'd0, e.o});
          chk("underflow_out", {31'd0, underflow_out}, {31'd0, e.u});
          chk("in_ready_busy", {31'd0, in_ready},      32'd0);
          if (out_ready) begin
            void'(q.pop_front());
            first = 1'b1;
            hs_prev = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(sum_in, exp_in, sign_in);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [24:0] s, input logic [7:0] e, input logic sg);
    int t = 0;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end else begin
      in_valid = 1'b1; sum_in = s; exp_in = e; sign_in = sg;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || !in_ready) && t < 300) begin
      @(posedge clk); #1; t++;
    end
    if (q.size() != 0 || !in_ready) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending=%0d in_ready=%0d, required 0 and 1", q.size(), in_ready);
    end
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},      32'd1);
    chk("rst_out_valid", {31'd0, out_valid},     32'd0);
    chk("rst_sign",      {31'd0, sign_out},      32'd0);
    chk("rst_exp",       {24'd0, exp_out},       32'd0);
    chk("rst_ment",      {9'd0, ment_out},       32'd0);
    chk("rst_zero",      {31'd0, zero_out},      32'd0);
    chk("rst_ovf",       {31'd0, overflow_out},  32'd0);
    chk("rst_unf",       {31'd0, underflow_out}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t m;
    int   t;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sum_in = '0; exp_in = '0; sign_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();

    // Hand-computed values that pin the reference.
    m = model(25'h1800000, 8'd127, 1'b0);
    chk("pin_carry_exp", {24'd0, m.exp}, 32'd128);
    chk("pin_carry_ment", {9'd0, m.ment}, 32'h400000);
    chk("pin_carry_lat", 32'(m.lat), 32'd2);
    m = model(25'h0000000, 8'd130, 1'b0);
    chk("pin_zero_flag", {31'd0, m.z}, 32'd1);
    m = model(25'h0100000, 8'd130, 1'b0);
    chk("pin_shift3_exp", {24'd0, m.exp}, 32'd127);
    chk("pin_shift3_lat", 32'(m.lat), 32'd5);
    m = model(25'h1000000, 8'd254, 1'b1);
    chk("pin_ovf", {29'd0, m.sign, m.o, m.exp == 8'hFF}, 32'h7);
    m = model(25'h0000001, 8'd5, 1'b0);
    chk("pin_unf", {30'd0, m.u, m.z}, 32'h3);
    chk("pin_unf_lat", 32'(m.lat), 32'd6);

    // Directed vectors (test plan and boundaries).
    send(25'h1800000, 8'd127, 1'b0); drain();
    send(25'h0000000, 8'd130, 1'b0); drain();
    send(25'h0100000, 8'd130, 1'b0); drain();
    send(25'h1000000, 8'd254, 1'b1); drain();
    send(25'h0000001, 8'd5,   1'b0); drain();
    send(25'h1FFFFFF, 8'd10,  1'b1); drain();
    send(25'h0ABCDEF, 8'd100, 1'b0); drain();
    send(25'h0ABCDEF, 8'd255, 1'b0); drain();
    send(25'h0400000, 8'd1,   1'b1); drain();
    send(25'h0000000, 8'd0,   1'b1); drain();
    send(25'h0000001, 8'd24,  1'b0); drain();
    send(25'h0000001, 8'd23,  1'b0); drain();
    send(25'h0400000, 8'd2,   1'b1); drain();
    for (int i = 0; i < 8; i++) begin
      send(25'($urandom_range(0, 32'h1FFFFFF)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      drain();
    end

    // Back-pressure: hold DONE for 5 cycles; the compare process re-checks each cycle.
    out_ready = 1'b0;
    send(25'h1800000, 8'd127, 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset during SHIFT discards the operation.
    send(25'h0000001, 8'd100, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();
    send(25'h0100000, 8'd130, 1'b1); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
